// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple dual-port byte-enable RAM.
package ram_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } ram_state_e;

   // Upper bounds for the generic merge helper; the top checks its parameters against them.
   localparam int MAX_DATA_WIDTH = 256;
   localparam int MAX_BYTES      = 256;

   function automatic int num_bytes(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

   // Written lanes come from new_word, the rest from old_word.
   function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_BYTES-1:0]      be,
      input int                        byte_width
   );
      logic [MAX_DATA_WIDTH-1:0] merged;
      for (int b = 0; b < MAX_DATA_WIDTH; b++) begin
         merged[b] = be[8'(b / byte_width)] ? new_word[b] : old_word[b];
      end
      return merged;
   endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// Post-reset clear sequencer: walks every address once, then hands the array to normal traffic.
module ram_clr_ctrl
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam logic [0:0] ST_CLEAR = CLEAR;
   localparam logic [0:0] ST_RUN   = RUN;

   logic [0:0] state;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_CLEAR;
         clr_addr <= '0;
      end else if (state == ST_CLEAR) begin
         clr_addr <= clr_addr + 1'b1;
         if (clr_addr == '1) begin
            state <= ST_RUN;
         end
      end
   end

   assign busy = (state == ST_CLEAR);

endmodule

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with byte-lane write enables and a post-reset clear sweep.
// Define RAM_SDP_BE_OUT_REG_EN to add an output pipeline register (2-cycle read latency).
module ram_sdp_be
   import ram_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int ADDR_WIDTH = 8,
   parameter  int BYTE_WIDTH = 8,
   parameter  int RDW_MODE   = 0,
   localparam int NUM_BYTES  = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [NUM_BYTES-1:0]  wbe,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $error("ram_sdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end
   if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_too_wide
      $error("ram_sdp_be: DATA_WIDTH exceeds MAX_DATA_WIDTH");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] clr_addr;

   ram_clr_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clr_ctrl (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy),
      .clr_addr (clr_addr)
   );

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NUM_BYTES-1:0]  wr_be;

   // NOTE: every signal gets a default before the branches, so no latches are inferred.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = waddr;
      wr_data = wdata;
      wr_be   = wbe;
      if (rst) begin
         wr_en = 1'b0;
      end else if (busy) begin
         wr_en   = 1'b1;
         wr_addr = clr_addr;
         wr_data = '0;
         wr_be   = '1;
      end else begin
         wr_en = we;
      end
   end

   // NOTE: the array has no reset; the clear sweep zeroes it so it still maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (wr_be[i]) begin
               mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   logic                  rd_en;
   logic                  rdw_hit;
   logic [DATA_WIDTH-1:0] rd_merged;
   logic [DATA_WIDTH-1:0] rdata_s1;
   logic                  rvalid_s1;

   assign rd_en   = re && !busy;
   assign rdw_hit = (RDW_MODE == 1) && we && (waddr == raddr);

   always_comb begin
      rd_merged = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(mem[raddr]),
                                         MAX_DATA_WIDTH'(wdata),
                                         MAX_BYTES'(wbe),
                                         BYTE_WIDTH));
   end

   // The plain array read sees the word before this edge's write (old-data behaviour).
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_s1  <= '0;
         rvalid_s1 <= 1'b0;
      end else begin
         rvalid_s1 <= rd_en;
         if (rd_en) begin
            rdata_s1 <= rdw_hit ? rd_merged : mem[raddr];
         end
      end
   end

`ifdef RAM_SDP_BE_OUT_REG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rdata  <= rdata_s1;
         rvalid <= rvalid_s1;
      end
   end
`else
   assign rdata  = rdata_s1;
   assign rvalid = rvalid_s1;
`endif

endmodule

// File: tb/tb_ram_sdp_be.sv
// Self-checking bench for ram_sdp_be: one instance per read-during-write mode, checked
// every cycle against a word-level model plus hand-computed literal expectations.
module tb_ram_sdp_be;

   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 2 ** AW;
`ifdef RAM_SDP_BE_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          we;
   logic [3:0]    wbe;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          re;
   logic [AW-1:0] raddr;

   logic [DW-1:0] dut_rdata  [2];
   logic          dut_rvalid [2];
   logic          dut_busy   [2];

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   ram_sdp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RDW_MODE(0)) u_dut0 (
      .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(dut_rdata[0]), .rvalid(dut_rvalid[0]), .busy(dut_busy[0])
   );

   ram_sdp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RDW_MODE(1)) u_dut1 (
      .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(dut_rdata[1]), .rvalid(dut_rvalid[1]), .busy(dut_busy[1])
   );

   // Word-level model: reset zeroes the whole array at once, since nothing is observable mid-sweep.
   logic [DW-1:0] m_mem [DEPTH];
   int            m_busy;
   logic [DW-1:0] m_s1d [2];
   logic [DW-1:0] m_s2d [2];
   logic          m_s1v [2];
   logic          m_s2v [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [DW-1:0] mask;
      logic [DW-1:0] merged;
      if (rst) begin
         for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
         m_busy = DEPTH;
         for (int m = 0; m < 2; m++) begin
            m_s1d[m] = '0; m_s1v[m] = 1'b0; m_s2d[m] = '0; m_s2v[m] = 1'b0;
         end
         return;
      end
      for (int m = 0; m < 2; m++) begin
         m_s2d[m] = m_s1d[m];
         m_s2v[m] = m_s1v[m];
      end
      if (m_busy > 0) begin
         m_busy--;
         for (int m = 0; m < 2; m++) m_s1v[m] = 1'b0;
      end else begin
         mask = '0;
         for (int i = 0; i < 4; i++) if (wbe[i]) mask |= 32'hFF << (8 * i);
         merged = (m_mem[waddr] & ~mask) | (wdata & mask);
         for (int m = 0; m < 2; m++) begin
            m_s1v[m] = re;
            if (re) m_s1d[m] = (m == 1 && we && waddr == raddr) ? merged : m_mem[raddr];
         end
         if (we) m_mem[waddr] = merged;
      end
   endtask

   // Inputs change on the falling edge; the model samples them right after the rising edge.
   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int m = 0; m < 2; m++) begin
            check($sformatf("cmp_busy%0d", m), 32'(dut_busy[m]), 32'(m_busy > 0));
            check($sformatf("cmp_rvalid%0d", m), 32'(dut_rvalid[m]),
                  32'((LAT == 2) ? m_s2v[m] : m_s1v[m]));
            check($sformatf("cmp_rdata%0d", m), dut_rdata[m],
                  (LAT == 2) ? m_s2d[m] : m_s1d[m]);
         end
      end
   end

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
      we = 1'b1; waddr = a; wdata = d; wbe = be;
      cyc();
      we = 1'b0; wbe = '0;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      re = 1'b1; raddr = a;
      cyc();
      re = 1'b0;
      repeat (LAT - 1) cyc();
   endtask

   task automatic expect_both(input string name, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      check({name, "_rdata0"}, dut_rdata[0], d0);
      check({name, "_rdata1"}, dut_rdata[1], d1);
      check({name, "_rvalid0"}, 32'(dut_rvalid[0]), 32'd1);
      check({name, "_rvalid1"}, 32'(dut_rvalid[1]), 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (dut_busy[0] && n < DEPTH + 8) begin
         cyc();
         n++;
      end
      check("idle_timeout", 32'(dut_busy[0]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; we = 1'b0; wbe = '0; waddr = '0; wdata = '0; re = 1'b0; raddr = '0;
      cyc();
      chk_en = 1'b1;
      cyc();
      for (int m = 0; m < 2; m++) begin
         check("reset_rdata", dut_rdata[m], 32'h0);
         check("reset_rvalid", 32'(dut_rvalid[m]), 32'd0);
         check("reset_busy", 32'(dut_busy[m]), 32'd1);
      end

      // Sweep length, with an access attempt on the second sweep edge.
      rst = 1'b0;
      n = 0;
      while (1) begin
         if (n == 1) begin
            we = 1'b1; waddr = 8'd5; wdata = '1; wbe = '1; re = 1'b1; raddr = 8'd5;
         end else begin
            we = 1'b0; wbe = '0; re = 1'b0;
         end
         cyc();
         n++;
         if (n == 2) check("busy_rvalid", 32'(dut_rvalid[0]), 32'd0);
         if (!dut_busy[0] || n >= DEPTH + 8) break;
      end
      we = 1'b0; wbe = '0; re = 1'b0;
      check("sweep_len", n, DEPTH);

      // Every address reads back zero, back to back.
      for (int i = 0; i < DEPTH; i++) begin
         re = 1'b1; raddr = AW'(i);
         cyc();
      end
      re = 1'b0;
      repeat (LAT) cyc();
      rd(8'd5);
      expect_both("busy_write_ignored", 32'h0, 32'h0);
      check("model_addr5", m_mem[5], 32'h0);

      // Byte enables, and an empty enable mask.
      wr(8'd3, 32'hAABBCCDD, 4'b1111);
      wr(8'd3, 32'h11223344, 4'b0101);
      rd(8'd3);
      expect_both("byte_en", 32'hAA22CC44, 32'hAA22CC44);
      check("model_byte_en", m_mem[3], 32'hAA22CC44);
      wr(8'd3, 32'h00000000, 4'b0000);
      rd(8'd3);
      expect_both("wbe_zero", 32'hAA22CC44, 32'hAA22CC44);

      // re=0 holds rdata and drops rvalid.
      cyc();
      cyc();
      check("hold_rdata", dut_rdata[0], 32'hAA22CC44);
      check("hold_rvalid", 32'(dut_rvalid[0]), 32'd0);

      // Read-during-write on the same address.
      wr(8'd7, 32'h00000005, 4'b1111);
      we = 1'b1; waddr = 8'd7; wdata = 32'h000000FF; wbe = 4'b0001; re = 1'b1; raddr = 8'd7;
      cyc();
      we = 1'b0; wbe = '0; re = 1'b0;
      repeat (LAT - 1) cyc();
      expect_both("rdw_a7", 32'h00000005, 32'h000000FF);
      rd(8'd7);
      expect_both("rdw_after", 32'h000000FF, 32'h000000FF);

      wr(8'd8, 32'h11223344, 4'b1111);
      we = 1'b1; waddr = 8'd8; wdata = 32'hAABBCCDD; wbe = 4'b1010; re = 1'b1; raddr = 8'd8;
      cyc();
      we = 1'b0; wbe = '0; re = 1'b0;
      repeat (LAT - 1) cyc();
      expect_both("rdw_merge", 32'h11223344, 32'hAA22CC44);
      check("model_rdw_merge", m_mem[8], 32'hAA22CC44);

      // Different addresses on the same edge are independent.
      we = 1'b1; waddr = 8'd10; wdata = 32'h0BADF00D; wbe = 4'b1111; re = 1'b1; raddr = 8'd3;
      cyc();
      we = 1'b0; wbe = '0; re = 1'b0;
      repeat (LAT - 1) cyc();
      expect_both("diff_addr", 32'hAA22CC44, 32'hAA22CC44);
      rd(8'd10);
      expect_both("diff_addr_wr", 32'h0BADF00D, 32'h0BADF00D);

      // Address boundaries.
      wr(8'd255, 32'hDEADBEEF, 4'b1111);
      wr(8'd0, 32'hCAFEF00D, 4'b1111);
      rd(8'd255);
      expect_both("addr_max", 32'hDEADBEEF, 32'hDEADBEEF);
      rd(8'd0);
      expect_both("addr_min", 32'hCAFEF00D, 32'hCAFEF00D);

      // Reset on the same edge as a read aborts it and restarts the sweep.
      wr(8'd9, 32'h12345678, 4'b1111);
      rst = 1'b1; re = 1'b1; raddr = 8'd9;
      cyc();
      re = 1'b0; rst = 1'b0;
      for (int m = 0; m < 2; m++) begin
         check("midrst_rvalid", 32'(dut_rvalid[m]), 32'd0);
         check("midrst_rdata", dut_rdata[m], 32'h0);
         check("midrst_busy", 32'(dut_busy[m]), 32'd1);
      end
      wait_idle();
      rd(8'd9);
      expect_both("midrst_a9", 32'h0, 32'h0);
      rd(8'd255);
      expect_both("midrst_a255", 32'h0, 32'h0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
